// File: rtl/fib_stack_unit.sv
// Frame stack for the Fibonacci recursion controller: saves {n, flag, ret} on push,
// restores the top frame on pop, and acknowledges every request with a readySig pulse.
module fib_stack_unit #(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pushSig,
    input  logic              popSig,
    input  logic [DATA_W-1:0] n_in,
    input  logic [DATA_W-1:0] flag_in,
    input  logic [DATA_W-1:0] ret_in,
    output logic [DATA_W-1:0] n_out,
    output logic [DATA_W-1:0] flag_out,
    output logic [DATA_W-1:0] ret_out,
    output logic              readySig,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       count,
    output logic              ovf,
    output logic              udf
);

    localparam int unsigned FW = 3 * DATA_W;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        LOAD,
        DONE
    } state_t;

    state_t        state;
    logic [FW-1:0] mem [DEPTH];
    logic [FW-1:0] rd_q;
    logic [AW-1:0] rd_addr;

    // Top of stack lives at count-1; only used while the stack is non-empty.
    assign rd_addr = AW'(count - (AW+1)'(1));

    // Frame RAM: one write port, one synchronous read port, contents not reset.
    always_ff @(posedge clk) begin
        if (state == WRITE && !full) begin
            mem[count[AW-1:0]] <= {n_in, flag_in, ret_in};
        end
        if (state == READ) begin
            rd_q <= mem[rd_addr];
        end
    end

    // Request sequencer; empty/full are kept registered alongside count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            readySig <= 1'b0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
            n_out    <= '0;
            flag_out <= '0;
            ret_out  <= '0;
        end else begin
            readySig <= 1'b0;
            case (state)
                IDLE: begin
                    if (pushSig && popSig) begin
                        state    <= DONE;
                        readySig <= 1'b1;
                    end else if (pushSig) begin
                        state <= WRITE;
                    end else if (popSig) begin
                        state <= READ;
                    end
                end
                WRITE: begin
                    if (!full) begin
                        count <= count + (AW+1)'(1);
                        empty <= 1'b0;
                        full  <= (count == (AW+1)'(DEPTH - 1));
                    end else begin
                        ovf <= 1'b1;
                    end
                    state    <= DONE;
                    readySig <= 1'b1;
                end
                READ: begin
                    if (!empty) begin
                        state <= LOAD;
                    end else begin
                        udf      <= 1'b1;
                        state    <= DONE;
                        readySig <= 1'b1;
                    end
                end
                LOAD: begin
                    {n_out, flag_out, ret_out} <= rd_q;
                    count    <= count - (AW+1)'(1);
                    full     <= 1'b0;
                    empty    <= (count == (AW+1)'(1));
                    state    <= DONE;
                    readySig <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_stack_unit.sv
// Bench for fib_stack_unit: directed scenarios plus random push/pop traffic
// checked against a queue-based model of the frame stack.
module tb_fib_stack_unit;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pushSig = 1'b0;
    logic          popSig = 1'b0;
    logic [DW-1:0] n_in = '0, flag_in = '0, ret_in = '0;
    logic [DW-1:0] n_out, flag_out, ret_out;
    logic          readySig, empty, full, ovf, udf;
    logic [AW:0]   count;

    fib_stack_unit #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .pushSig(pushSig), .popSig(popSig),
        .n_in(n_in), .flag_in(flag_in), .ret_in(ret_in),
        .n_out(n_out), .flag_out(flag_out), .ret_out(ret_out),
        .readySig(readySig), .empty(empty), .full(full), .count(count),
        .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    logic [3*DW-1:0] model_q [$];
    logic [3*DW-1:0] model_out;
    logic            model_ovf, model_udf;
    int              tests = 0;
    int              fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'(model_q.size()));
        check({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
        check({tag, "_full"},  32'(full),  32'(model_q.size() == DEPTH));
        check({tag, "_ovf"},   32'(ovf),   32'(model_ovf));
        check({tag, "_udf"},   32'(udf),   32'(model_udf));
        check({tag, "_out"},   32'({n_out, flag_out, ret_out}), 32'(model_out));
    endtask

    task automatic model_clear();
        model_q.delete();
        model_out = '0;
        model_ovf = 1'b0;
        model_udf = 1'b0;
    endtask

    task automatic do_reset();
        pushSig = 1'b0;
        popSig  = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE, wait (bounded) for readySig, then check everything.
    task automatic request(input string tag, input logic push, input logic pop,
                           input logic [3*DW-1:0] frame);
        int exp_lat;
        int cyc;
        if (push && pop) begin
            exp_lat = 1;
        end else if (push) begin
            exp_lat = 2;
            if (model_q.size() < DEPTH) model_q.push_back(frame);
            else model_ovf = 1'b1;
        end else begin
            if (model_q.size() > 0) begin
                exp_lat   = 3;
                model_out = model_q.pop_back();
            end else begin
                exp_lat   = 2;
                model_udf = 1'b1;
            end
        end
        {n_in, flag_in, ret_in} = frame;
        pushSig = push;
        popSig  = pop;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!readySig && cyc < 8);
        pushSig = 1'b0;
        popSig  = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check_state(tag);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(readySig), 32'd0);
    endtask

    initial begin
        model_clear();
        #12;
        do_reset();
        check("reset_ready", 32'(readySig), 32'd0);
        check_state("reset");

        request("push_first", 1'b1, 1'b0, {8'd3, 8'd1, 8'd0});

        do_reset();
        request("push_a", 1'b1, 1'b0, {8'd5, 8'd1, 8'd0});
        request("push_b", 1'b1, 1'b0, {8'd4, 8'd2, 8'd7});
        request("pop_b", 1'b0, 1'b1, 24'h0);
        request("pop_a", 1'b0, 1'b1, 24'h0);

        request("pop_empty", 1'b0, 1'b1, 24'h0);

        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            request("fill", 1'b1, 1'b0, {8'(i + 1), 8'(i * 3), 8'(255 - i)});
        end
        request("pop_full", 1'b0, 1'b1, 24'h0);
        request("both", 1'b1, 1'b1, 24'habcdef);
        for (int i = 0; i < DEPTH; i++) begin
            request("drain", 1'b0, 1'b1, 24'h0);
        end

        // Reset asserted while the pop is in LOAD.
        do_reset();
        request("pre_load", 1'b1, 1'b0, 24'h123456);
        popSig = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        popSig = 1'b0;
        rst_n  = 1'b0;
        #1;
        model_clear();
        check("rst_load_ready", 32'(readySig), 32'd0);
        check_state("rst_load");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        request("after_rst_pop", 1'b0, 1'b1, 24'h0);
        request("after_rst_push", 1'b1, 1'b0, 24'h0a0b0c);

        do_reset();
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            logic [3*DW-1:0] f;
            r = $urandom_range(99);
            f = 24'($urandom);
            if (r < 55)      request("rnd_push", 1'b1, 1'b0, f);
            else if (r < 88) request("rnd_pop", 1'b0, 1'b1, f);
            else             request("rnd_both", 1'b1, 1'b1, f);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
